// File: rtl/rom_if_pkg.sv
// Shared definitions for the rom_AxB read-interface initiator.
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   SEL_*                   : strobe-select encodings (bit 0 = read_one, bit 1 = read_two)
//   rd_state_e              : burst reader FSM states
package rom_if_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic [1:0] SEL_ONE  = 2'b01;
  localparam logic [1:0] SEL_TWO  = 2'b10;
  localparam logic [1:0] SEL_BOTH = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FIN   = 3'd4
  } rd_state_e;

  // An all-zero select means "read_one" so a burst always strobes something.
  function automatic logic [1:0] norm_sel(input logic [1:0] s);
    return (s == 2'b00) ? SEL_ONE : s;
  endfunction

endpackage

// File: rtl/rom_out_reg.sv
// Single-entry valid/ready holding register for captured ROM words.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_data and raise valid
//   load_data  : word to capture
//   ready      : consumer ready; valid && ready completes the transfer
//   data       : held word
//   valid      : data is valid
module rom_out_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  // Load takes priority; a completed handshake empties the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rom_burst_reader.sv
// Burst read controller for the rom_AxB interface: walks a contiguous,
// wrapping address range, strobes the ROM once per word and hands each
// captured byte to a single-entry valid/ready output stream.
//   clk, rst          : clock, synchronous active-high reset
//   start             : burst request, accepted only when idle
//   base_addr/length  : burst first address / word count (0 = empty burst)
//   sel               : strobe select (01 one, 10 two, 11 both, 00 -> 01)
//   busy, done        : burst in progress / one-cycle completion pulse
//   rom_address       : ROM address, parked at 0 between reads
//   rom_read_one/two  : ROM read strobes
//   rom_data          : ROM read data
//   out_data/out_valid/out_ready : captured word stream
module rom_burst_reader
  import rom_if_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [1:0]        sel,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_read_one,
  output logic              rom_read_two,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned WCNT_W = 3;

  rd_state_e         state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [ADDR_W-1:0] cnt_q, cnt_n;
  logic [1:0]        sel_q, sel_n;
  logic [WCNT_W-1:0] wcnt_q, wcnt_n;
  logic              load_c;
  logic              hs_c;

  assign hs_c = (state_q == ST_HOLD) && out_valid && out_ready;

  // State and burst-context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      cnt_q   <= cnt_n;
      sel_q   <= sel_n;
      wcnt_q  <= wcnt_n;
    end
  end

  // Next-state and burst-context update.
  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    cnt_n   = cnt_q;
    sel_n   = sel_q;
    wcnt_n  = wcnt_q;
    load_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_n  = base_addr;
            cnt_n   = length;
            sel_n   = norm_sel(sel);
            state_n = ST_ISSUE;
          end else begin
            state_n = ST_FIN;
          end
        end
      end
      ST_ISSUE: begin
        wcnt_n  = '0;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        // rom_data is sampled at the end of the last wait cycle.
        if (wcnt_q == WCNT_W'(RD_WAIT - 1)) begin
          load_c  = 1'b1;
          state_n = ST_HOLD;
        end else begin
          wcnt_n = wcnt_q + WCNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (hs_c) begin
          addr_n  = addr_q + ADDR_W'(1);
          cnt_n   = cnt_q - ADDR_W'(1);
          state_n = (cnt_q == ADDR_W'(1)) ? ST_FIN : ST_ISSUE;
        end
      end
      ST_FIN: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Outputs registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      rom_address  <= '0;
      rom_read_one <= 1'b0;
      rom_read_two <= 1'b0;
    end else begin
      busy         <= (state_n != ST_IDLE);
      done         <= (state_n == ST_FIN);
      rom_address  <= ((state_n == ST_ISSUE) || (state_n == ST_WAIT)) ? addr_n : '0;
      rom_read_one <= (state_n == ST_ISSUE) && sel_n[0];
      rom_read_two <= (state_n == ST_ISSUE) && sel_n[1];
    end
  end

  rom_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .load_data (rom_data),
    .ready     (out_ready),
    .data      (out_data),
    .valid     (out_valid)
  );

endmodule
